// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the divider arbiter: FSM state encoding and default widths.
package div_arb_pkg;

  localparam int DEF_N    = 4;
  localparam int DEF_NREQ = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ZRESP = 3'd4
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo NREQ.
module rr_pick
  import div_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic          found;
  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = 0;
    jj       = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && req_i[jj]) begin
        found        = 1'b1;
        onehot_o[jj] = 1'b1;
        idx_o        = jj;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider among NREQ requesters.
// Optional DIV_ARB_ZERO_CHECK_EN answers divide-by-zero locally with rsp_err instead of using the divider.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*N-1:0] req_dividendo,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rsp_valid,
  output logic [N-1:0]    rsp_quot,
  output logic [N-1:0]    rsp_rem,
  output logic            rsp_err,
  output logic            div_start,
  output logic [N-1:0]    div_dividendo,
  output logic [N-1:0]    div_divisor,
  input  logic            div_done,
  input  logic [N-1:0]    div_quot,
  input  logic [N:0]      div_rem
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   g_q, g_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    dvs_q, dvs_d;
`ifdef DIV_ARB_ZERO_CHECK_EN
  logic            rsp_err_q, rsp_err_d;
`endif

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [N-1:0]    sel_dvd, sel_dvs;
  logic [IW-1:0]   ptr_nxt;
  logic            unused_rem_msb;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign sel_dvd        = req_dividendo[pick_idx*N +: N];
  assign sel_dvs        = req_divisor[pick_idx*N +: N];
  assign ptr_nxt        = (g_q == IW'(NREQ-1)) ? '0 : g_q + 1'b1;
  // The divider's remainder carries an extra MSB that requesters never see.
  assign unused_rem_msb = div_rem[N];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
`ifdef DIV_ARB_ZERO_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          g_d   = pick_idx;
          gnt_d = pick_onehot;
          dvd_d = sel_dvd;
          dvs_d = sel_dvs;
`ifdef DIV_ARB_ZERO_CHECK_EN
          if (sel_dvs == '0) begin
            state_d     = S_ZRESP;
            rsp_valid_d = pick_onehot;
            rsp_err_d   = 1'b1;
            quot_d      = '1;
            rem_d       = sel_dvd;
          end else begin
            state_d = S_START;
          end
`else
          state_d = S_START;
`endif
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // Response registers load on the WAIT exit so rsp_valid is high exactly during RESP.
        if (div_done) begin
          state_d     = S_RESP;
          rsp_valid_d = gnt_q;
          quot_d      = div_quot;
          rem_d       = div_rem[N-1:0];
`ifdef DIV_ARB_ZERO_CHECK_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      S_RESP, S_ZRESP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_nxt;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
`ifdef DIV_ARB_ZERO_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
`ifdef DIV_ARB_ZERO_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign gnt           = gnt_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quot      = quot_q;
  assign rsp_rem       = rem_q;
  assign div_start     = (state_q == S_START);
  assign div_dividendo = dvd_q;
  assign div_divisor   = dvs_q;
`ifdef DIV_ARB_ZERO_CHECK_EN
  assign rsp_err       = rsp_err_q;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a 2-cycle behavioural divider; honours DIV_ARB_ZERO_CHECK_EN.
module tb_div_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] req_dividendo = '0;
  logic [NREQ*N-1:0] req_divisor = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [N-1:0]      rsp_quot, rsp_rem;
  logic              rsp_err, div_start;
  logic [N-1:0]      div_dividendo, div_divisor;
  logic              div_done;
  logic [N-1:0]      div_quot;
  logic [N:0]        div_rem;

  logic              mdl_done;
  logic              stray_done = 1'b0;
  logic              mdl_busy;
  int                mdl_cnt;
  int                n_start = 0;
  int                n_chk = 0;
  int                n_fail = 0;

  div_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_dividendo (req_dividendo),
    .req_divisor   (req_divisor),
    .gnt           (gnt),
    .rsp_valid     (rsp_valid),
    .rsp_quot      (rsp_quot),
    .rsp_rem       (rsp_rem),
    .rsp_err       (rsp_err),
    .div_start     (div_start),
    .div_dividendo (div_dividendo),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quot      (div_quot),
    .div_rem       (div_rem)
  );

  always #5 clk = ~clk;

  assign div_done = mdl_done | stray_done;

  // Divider model: result LAT cycles after the start edge; remainder MSB forced high.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
      div_quot <= '0;
      div_rem  <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (div_start && !mdl_busy) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= LAT;
      end else if (mdl_busy) begin
        if (mdl_cnt == 1) begin
          mdl_busy <= 1'b0;
          mdl_done <= 1'b1;
          if (div_divisor != '0) begin
            div_quot <= div_dividendo / div_divisor;
            div_rem  <= {1'b1, div_dividendo % div_divisor};
          end else begin
            div_quot <= '1;
            div_rem  <= {1'b1, div_dividendo};
          end
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) if (rst && div_start) n_start++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    req_dividendo[i*N +: N] = dvd;
    req_divisor[i*N +: N]   = dvs;
  endtask

  task automatic wait_rsp(input int maxc, output logic found, output int cyc,
                          output logic [NREQ-1:0] v);
    found = 1'b0;
    cyc   = 0;
    v     = '0;
    while (!found && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid !== '0) begin
        found = 1'b1;
        v     = rsp_valid;
      end
    end
  endtask

  logic            found;
  int              cyc;
  int              s0;
  logic [NREQ-1:0] v;
  logic [NREQ-1:0] exp_g [5];
  logic [N-1:0]    exp_q [5];
  logic [N-1:0]    exp_r [5];

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{4'd8, 4'd4, 4'd3, 4'd2, 4'd8};
    exp_r = '{4'd0, 4'd1, 4'd1, 4'd3, 4'd0};

    // Reset values
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_div_start", 32'(div_start), 32'h0);
    chk("rst_div_ops", 32'({div_dividendo, div_divisor}), 32'h0);
    chk("rst_rsp_data", 32'({rsp_quot, rsp_rem, rsp_err}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single request 13/3 from requester 1
    set_op(0, 4'd8, 4'd1);
    set_op(1, 4'd13, 4'd3);
    set_op(2, 4'd10, 4'd3);
    set_op(3, 4'd11, 4'd4);
    req = 4'b0010;
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_div_start", 32'(div_start), 32'h1);
    chk("single_ops", 32'({div_dividendo, div_divisor}), 32'hD3);
    wait_rsp(50, found, cyc, v);
    req = '0;
    chk("single_found", 32'(found), 32'h1);
    chk("single_latency", 32'(cyc + 1), 32'(3 + LAT));
    chk("single_valid", 32'(v), 32'h2);
    chk("single_quot", 32'(rsp_quot), 32'h4);
    chk("single_rem", 32'(rsp_rem), 32'h1);
    chk("single_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    chk("single_pulse_end", 32'(rsp_valid), 32'h0);
    chk("single_hold_quot", 32'(rsp_quot), 32'h4);
    chk("single_gnt_clear", 32'(gnt), 32'h0);
    chk("single_starts", 32'(n_start), 32'h1);

    // Contention from reset: all four held
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_rsp(50, found, cyc, v);
      if (t == 4) req = '0;
      chk("cont_found", 32'(found), 32'h1);
      chk($sformatf("cont_grant%0d", t), 32'(v), 32'(exp_g[t]));
      chk($sformatf("cont_quot%0d", t), 32'(rsp_quot), 32'(exp_q[t]));
      chk($sformatf("cont_rem%0d", t), 32'(rsp_rem), 32'(exp_r[t]));
    end
    @(negedge clk);

    // Fairness: requesters 2 and 3 continuously, ptr now 1
    req = 4'b1100;
    for (int t = 0; t < 20; t++) begin
      wait_rsp(50, found, cyc, v);
      if (t == 19) req = '0;
      chk($sformatf("fair_grant%0d", t), 32'(v), (t % 2 == 0) ? 32'h4 : 32'h8);
    end
    @(negedge clk);

    // Divide by zero 9/0 from requester 0 (ptr now 0)
    set_op(0, 4'd9, 4'd0);
    s0  = n_start;
    req = 4'b0001;
    wait_rsp(50, found, cyc, v);
    req = '0;
    chk("zero_found", 32'(found), 32'h1);
    chk("zero_valid", 32'(v), 32'h1);
    chk("zero_quot", 32'(rsp_quot), 32'hF);
    chk("zero_rem", 32'(rsp_rem), 32'h9);
`ifdef DIV_ARB_ZERO_CHECK_EN
    chk("zero_err", 32'(rsp_err), 32'h1);
    chk("zero_starts", 32'(n_start - s0), 32'h0);
`else
    chk("zero_err", 32'(rsp_err), 32'h0);
    chk("zero_starts", 32'(n_start - s0), 32'h1);
`endif
    @(negedge clk);

    // Reset while in WAIT (requester 2), then ptr must be back at 0
    req = 4'b0100;
    @(negedge clk);
    chk("rw_start", 32'(div_start), 32'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rw_in_wait_gnt", 32'(gnt), 32'h4);
    rst = 1'b0;
    #1;
    chk("rw_gnt", 32'(gnt), 32'h0);
    chk("rw_outs", 32'({div_start, div_dividendo, div_divisor, rsp_quot, rsp_rem, rsp_err}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_rsp(10, found, cyc, v);
    chk("rw_no_rsp", 32'(found), 32'h0);
    set_op(0, 4'd14, 4'd5);
    req = 4'b1001;
    wait_rsp(50, found, cyc, v);
    req = '0;
    chk("rw_after_valid", 32'(v), 32'h1);
    chk("rw_after_quot", 32'(rsp_quot), 32'h2);
    chk("rw_after_rem", 32'(rsp_rem), 32'h4);
    @(negedge clk);

    // Stray div_done in IDLE, then requester 3 drops req during WAIT
    s0 = n_start;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    chk("stray_gnt", 32'(gnt), 32'h0);
    chk("stray_valid", 32'(rsp_valid), 32'h0);
    chk("stray_start", 32'(div_start), 32'h0);
    @(negedge clk);
    chk("stray_valid2", 32'(rsp_valid), 32'h0);
    set_op(3, 4'd15, 4'd2);
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    wait_rsp(50, found, cyc, v);
    chk("drop_found", 32'(found), 32'h1);
    chk("drop_valid", 32'(v), 32'h8);
    chk("drop_quot", 32'(rsp_quot), 32'h7);
    chk("drop_rem", 32'(rsp_rem), 32'h1);
    chk("drop_starts", 32'(n_start - s0), 32'h1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
